// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared constants and types for the 10x5 systolic array and its drain-side
// collector.
//   SA_DATA_WIDTH : width of one result word
//   SA_ROWS       : number of PE rows in the array
//   SA_COLS       : number of PE columns / result lanes
//   drain_state_e : state encoding of the drain collector FSM
// ---------------------------------------------------------------------------
package sa_pkg;

    localparam int SA_DATA_WIDTH = 32;
    localparam int SA_ROWS       = 10;
    localparam int SA_COLS       = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } drain_state_e;

endpackage

// File: rtl/systolic_drain_collector_if.sv
// ---------------------------------------------------------------------------
// systolic_drain_collector_if
// Row hand-off bus between the drain collector and the NICE write-back path.
//   out_valid : an aligned row is presented          (collector -> consumer)
//   out_data  : the row, lane j = array column j     (collector -> consumer)
//   out_ready : consumer accepts the row this cycle  (consumer  -> collector)
// Modports:
//   master : the collector side
//   slave  : the write-back side
// ---------------------------------------------------------------------------
interface systolic_drain_collector_if #(
    parameter int DATA_WIDTH = 32,
    parameter int COLS       = 5
);

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data [COLS];
    logic                  out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/sa_col_fifo.sv
// ---------------------------------------------------------------------------
// sa_col_fifo
// Single-column synchronous FIFO used to de-skew one lane of the systolic
// array drain stream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data
//   pop        : read request (head advances at the clock edge)
//   flush      : empties the FIFO; wins over push and pop
//   dout       : current head word (valid when !empty)
//   empty/full : occupancy flags
//   ovf        : strobe, a push was refused because the FIFO was full
// Parameters: DATA_WIDTH, DEPTH (power of two, >= 2)
// ---------------------------------------------------------------------------
module sa_col_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic                  ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  do_push;
    logic                  do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy counter.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle; the new word lands in the slot being vacated.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign ovf     = push && full && !do_pop && !flush;

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is read from it until it has been
    // written behind a valid pointer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/systolic_drain_collector.sv
// ---------------------------------------------------------------------------
// systolic_drain_collector
// Collects the column-staggered result stream leaving the bottom edge of the
// systolic array, re-aligns it into rows of COLS words using one FIFO per
// column, and hands rows to the write-back path over valid/ready. Rows are
// counted against a programmed total and completion is pulsed on done.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle restart: load cfg_rows, flush FIFOs, clear counter
//                and overflow, enter COLLECT
//   cfg_rows   : number of rows to collect, sampled on start
//   en_in      : per-column valid from the array's en_down
//   data_in    : per-column result word from the array's data_down
//   row_if     : row hand-off bus (out_valid / out_data / out_ready)
//   busy       : high while collecting
//   done       : one-cycle pulse after the final row is accepted
//   overflow   : sticky, a push hit a full column FIFO
// Configuration macro:
//   SA_DRAIN_RELU_EN : when defined, every out_data lane is treated as
//                      signed and negative values are presented as 0.
// ---------------------------------------------------------------------------
module systolic_drain_collector
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COLS       = 5,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       cfg_rows,
    input  logic [COLS-1:0]        en_in,
    input  logic [DATA_WIDTH-1:0]  data_in [COLS],
    systolic_drain_collector_if.master row_if,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    drain_state_e          state_q, state_d;
    logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]      cfg_rows_q, cfg_rows_d;
    logic                  overflow_q, overflow_d;

    logic [COLS-1:0]       push_vec;
    logic [COLS-1:0]       fifo_empty;
    logic [COLS-1:0]       fifo_full_unused;
    logic [COLS-1:0]       fifo_ovf;
    logic [DATA_WIDTH-1:0] head [COLS];
    logic                  accepting;
    logic                  row_valid;
    logic                  fire;

    // Pushes only land while collecting; the start cycle itself flushes, so
    // anything arriving with it is discarded.
    assign accepting = (state_q == COLLECT) && !start;
    assign push_vec  = en_in & {COLS{accepting}};

    // A row exists once every column has at least one word. The consumer's
    // ready never feeds back into valid.
    assign row_valid = accepting && (fifo_empty == '0);
    assign fire      = row_valid && row_if.out_ready;

    // The per-column full flag is not needed here: the FIFO already reports
    // refused pushes through ovf.
    for (genvar g = 0; g < COLS; g++) begin : g_col
        sa_col_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_vec[g]),
            .pop   (fire),
            .flush (start),
            .din   (data_in[g]),
            .dout  (head[g]),
            .empty (fifo_empty[g]),
            .full  (fifo_full_unused[g]),
            .ovf   (fifo_ovf[g])
        );
    end

    // Row presentation: heads are zeroed whenever no row is offered so the
    // bus never shows stale or partial data.
    always_comb begin
        row_if.out_valid = row_valid;
        for (int j = 0; j < COLS; j++) begin
            row_if.out_data[j] = '0;
            if (row_valid) begin
`ifdef SA_DRAIN_RELU_EN
                if (!head[j][DATA_WIDTH-1]) begin
                    row_if.out_data[j] = head[j];
                end
`else
                row_if.out_data[j] = head[j];
`endif
            end
        end
    end

    // Next-state logic. start overrides every state. In COLLECT the counter
    // is compared after the optional increment, which also covers a zero row
    // request: the counter already matches on the first COLLECT cycle.
    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        cfg_rows_d = cfg_rows_q;
        overflow_d = overflow_q;

        if (start) begin
            state_d    = COLLECT;
            row_cnt_d  = '0;
            cfg_rows_d = cfg_rows;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                COLLECT: begin
                    if (|fifo_ovf) begin
                        overflow_d = 1'b1;
                    end
                    if (fire) begin
                        row_cnt_d = row_cnt_q + CNT_ONE;
                    end
                    if (row_cnt_d == cfg_rows_q) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            cfg_rows_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            cfg_rows_q <= cfg_rows_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == COLLECT);
    assign done     = (state_q == DONE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_systolic_drain_collector.sv
// ---------------------------------------------------------------------------
// tb_systolic_drain_collector
// Self-checking bench for systolic_drain_collector. A queue-based model of
// the collector (one queue per column, a row count and a target) predicts
// every output each cycle; directed scenarios add literal expectations for
// skewed streaming, backpressure, overflow, full push/pop, restart, zero-row
// requests and the optional ReLU (SA_DRAIN_RELU_EN), followed by random
// traffic.
// ---------------------------------------------------------------------------
module tb_systolic_drain_collector;

    localparam int DW    = 32;
    localparam int COLS  = 5;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] cfg_rows;
    logic [COLS-1:0]  en_in;
    logic [DW-1:0]    data_in [COLS];
    logic             busy;
    logic             done;
    logic             overflow;

    systolic_drain_collector_if #(.DATA_WIDTH(DW), .COLS(COLS)) rowIf ();

    systolic_drain_collector #(
        .DATA_WIDTH (DW),
        .COLS       (COLS),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_rows (cfg_rows),
        .en_in    (en_in),
        .data_in  (data_in),
        .row_if   (rowIf),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Stimulus staging, consumed by applyStimulus
    logic [COLS-1:0] enDrv;
    logic [DW-1:0]   dataDrv [COLS];

    // Behavioural model
    logic [DW-1:0] mq [COLS][$];
    bit            mCollect;
    bit            mDonePulse;
    bit            mOvf;
    int            mCnt;
    int            mTarget;

    // Last sampled DUT outputs and handshake log
    bit            sValid, sBusy, sDone, sOvf;
    logic [DW-1:0] sData [COLS];
    int            hsLane0 [$];
    int            hsLane4 [$];
    int            doneSeen;
    int            doneCycle;
    int            cycleNo;

    int total = 0;
    int bad   = 0;

    function automatic logic [DW-1:0] expLane(input logic [DW-1:0] v);
`ifdef SA_DRAIN_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic compare(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    function automatic bit modelValid();
        bit v;
        v = mCollect && !start;
        for (int j = 0; j < COLS; j++) begin
            if (mq[j].size() == 0) v = 0;
        end
        return v;
    endfunction

    task automatic checkOutput();
        bit ev;
        logic [DW-1:0] ed;
        ev = modelValid();
        compare("out_valid", {31'd0, sValid}, {31'd0, ev});
        compare("busy", {31'd0, sBusy}, {31'd0, mCollect});
        compare("done", {31'd0, sDone}, {31'd0, mDonePulse});
        compare("overflow", {31'd0, sOvf}, {31'd0, mOvf});
        for (int j = 0; j < COLS; j++) begin
            ed = '0;
            if (ev) ed = expLane(mq[j][0]);
            compare($sformatf("out_data[%0d]", j), sData[j], ed);
        end
    endtask

    task automatic modelStep(input bit st, input int cfg, input bit rdy);
        bit fire;
        if (st) begin
            for (int j = 0; j < COLS; j++) mq[j].delete();
            mCnt       = 0;
            mTarget    = cfg;
            mOvf       = 0;
            mCollect   = 1;
            mDonePulse = 0;
        end else if (mCollect) begin
            fire = modelValid() && rdy;
            if (fire) begin
                for (int j = 0; j < COLS; j++) void'(mq[j].pop_front());
                mCnt++;
            end
            for (int j = 0; j < COLS; j++) begin
                if (enDrv[j]) begin
                    if (mq[j].size() < DEPTH) mq[j].push_back(dataDrv[j]);
                    else mOvf = 1;
                end
            end
            if (mCnt == mTarget) begin
                mCollect   = 0;
                mDonePulse = 1;
            end
        end else begin
            mDonePulse = 0;
        end
    endtask

    // One cycle: drive inputs after the falling edge, sample and check, then
    // advance the model to what the next rising edge should produce.
    task automatic applyStimulus(input bit st, input logic [CNT_W-1:0] cfg, input bit rdy);
        @(negedge clk);
        start           = st;
        cfg_rows        = cfg;
        en_in           = enDrv;
        data_in         = dataDrv;
        rowIf.out_ready = rdy;
        #1;
        sValid = rowIf.out_valid;
        sBusy  = busy;
        sDone  = done;
        sOvf   = overflow;
        for (int j = 0; j < COLS; j++) sData[j] = rowIf.out_data[j];
        checkOutput();
        if (sValid && rdy) begin
            hsLane0.push_back(int'(sData[0]));
            hsLane4.push_back(int'(sData[COLS-1]));
        end
        if (sDone) begin
            doneSeen++;
            doneCycle = cycleNo;
        end
        modelStep(st, int'(cfg), rdy);
        cycleNo++;
    endtask

    task automatic clearLog();
        hsLane0.delete();
        hsLane4.delete();
        doneSeen  = 0;
        doneCycle = -1;
        cycleNo   = 0;
    endtask

    task automatic idleDrive();
        enDrv = '0;
        for (int j = 0; j < COLS; j++) dataDrv[j] = '0;
    endtask

    // Column j carries row r in cycle 2+r+j after the start cycle.
    task automatic setDiag(input int c);
        int r;
        for (int j = 0; j < COLS; j++) begin
            r = c - 2 - j;
            enDrv[j]   = (r >= 0) && (r < 3);
            dataDrv[j] = ((r >= 0) && (r < 3)) ? DW'(100 * r + j) : '0;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        cfg_rows        = '0;
        en_in           = '0;
        rowIf.out_ready = 1'b0;
        for (int j = 0; j < COLS; j++) data_in[j] = '0;
        idleDrive();
        for (int j = 0; j < COLS; j++) mq[j].delete();
        mCollect = 0; mDonePulse = 0; mOvf = 0; mCnt = 0; mTarget = 0;
        clearLog();

        repeat (3) @(negedge clk);
        #1;
        compare("reset out_valid", {31'd0, rowIf.out_valid}, 32'd0);
        compare("reset out_data[0]", rowIf.out_data[0], 32'd0);
        compare("reset busy", {31'd0, busy}, 32'd0);
        compare("reset done", {31'd0, done}, 32'd0);
        compare("reset overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;

        // Diagonal skew, consumer always ready
        $display("[TB] diagonal skew");
        clearLog();
        for (int c = 0; c < 14; c++) begin
            setDiag(c);
            applyStimulus(c == 0, 8'd3, 1'b1);
        end
        compare("diag row count", hsLane0.size(), 32'd3);
        if (hsLane0.size() == 3) begin
            compare("diag row0 lane0", hsLane0[0], 32'd0);
            compare("diag row1 lane0", hsLane0[1], 32'd100);
            compare("diag row2 lane0", hsLane0[2], 32'd200);
            compare("diag row0 lane4", hsLane4[0], 32'd4);
            compare("diag row2 lane4", hsLane4[2], 32'd204);
        end
        compare("diag done count", doneSeen, 32'd1);
        compare("diag done cycle", doneCycle, 32'd10);

        // Backpressure until all data has arrived
        $display("[TB] backpressure");
        clearLog();
        for (int c = 0; c < 20; c++) begin
            setDiag(c);
            applyStimulus(c == 0, 8'd3, c >= 12);
            if (c == 9) compare("bp held lane0", sData[0], 32'd0);
            if (c == 11) compare("bp held lane4", sData[COLS-1], 32'd4);
        end
        compare("bp row count", hsLane0.size(), 32'd3);
        compare("bp done cycle", doneCycle, 32'd15);
        compare("bp overflow", {31'd0, sOvf}, 32'd0);

        // Overflow on column 0 only
        $display("[TB] overflow");
        clearLog();
        idleDrive();
        applyStimulus(1'b1, 8'd2, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            idleDrive();
            enDrv[0]   = 1'b1;
            dataDrv[0] = DW'(49 + c);
            applyStimulus(1'b0, 8'd2, 1'b0);
        end
        compare("ovf before 5th push lands", {31'd0, sOvf}, 32'd0);
        idleDrive();
        applyStimulus(1'b0, 8'd2, 1'b0);
        compare("ovf after 5th push", {31'd0, sOvf}, 32'd1);
        for (int c = 0; c < 2; c++) begin
            idleDrive();
            for (int j = 1; j < COLS; j++) begin
                enDrv[j]   = 1'b1;
                dataDrv[j] = DW'(60 + c);
            end
            applyStimulus(1'b0, 8'd2, 1'b1);
        end
        idleDrive();
        repeat (4) applyStimulus(1'b0, 8'd2, 1'b1);
        compare("ovf row count", hsLane0.size(), 32'd2);
        if (hsLane0.size() == 2) begin
            compare("ovf kept first word", hsLane0[0], 32'd50);
            compare("ovf kept second word", hsLane0[1], 32'd51);
        end

        // Simultaneous push and pop on full FIFOs
        $display("[TB] full push/pop");
        clearLog();
        idleDrive();
        applyStimulus(1'b1, 8'd10, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            enDrv = '1;
            for (int j = 0; j < COLS; j++) dataDrv[j] = DW'(1000 + 10 * c + j);
            applyStimulus(1'b0, 8'd10, c >= 5);
        end
        idleDrive();
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b0, 8'd10, 1'b1);
            if (c == 0) compare("full no overflow", {31'd0, sOvf}, 32'd0);
        end
        compare("full row count", hsLane0.size(), 32'd7);
        if (hsLane0.size() == 7) begin
            compare("full first row", hsLane0[0], 32'd1010);
            compare("full last row", hsLane0[6], 32'd1070);
        end

        // Restart mid-collect, then a zero-row request
        $display("[TB] restart and zero rows");
        clearLog();
        idleDrive();
        applyStimulus(1'b1, 8'd5, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            idleDrive();
            if (c <= 2) enDrv = '1; else enDrv[0] = 1'b1;
            for (int j = 0; j < COLS; j++) dataDrv[j] = 32'd7;
            applyStimulus(1'b0, 8'd5, 1'b0);
        end
        idleDrive();
        applyStimulus(1'b0, 8'd5, 1'b0);
        compare("rs rows buffered", {31'd0, sValid}, 32'd1);
        compare("rs overflow set", {31'd0, sOvf}, 32'd1);
        enDrv = '1;
        applyStimulus(1'b1, 8'd0, 1'b1);
        compare("rs valid in start cycle", {31'd0, sValid}, 32'd0);
        idleDrive();
        applyStimulus(1'b0, 8'd0, 1'b1);
        compare("rs valid after start", {31'd0, sValid}, 32'd0);
        compare("rs overflow cleared", {31'd0, sOvf}, 32'd0);
        compare("rs busy", {31'd0, sBusy}, 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b1);
        compare("zero rows done", {31'd0, sDone}, 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b1);
        compare("zero rows idle", {31'd0, sBusy}, 32'd0);
        compare("zero rows handshakes", hsLane0.size(), 32'd0);

        // Negative and positive lane values
        $display("[TB] relu lanes");
        clearLog();
        idleDrive();
        applyStimulus(1'b1, 8'd1, 1'b1);
        enDrv = '1;
        dataDrv[0] = 32'hFFFF_FFF6;
        dataDrv[1] = 32'd7;
        for (int j = 2; j < COLS; j++) dataDrv[j] = 32'd1;
        applyStimulus(1'b0, 8'd1, 1'b1);
        idleDrive();
        applyStimulus(1'b0, 8'd1, 1'b1);
`ifdef SA_DRAIN_RELU_EN
        compare("relu negative lane", sData[0], 32'd0);
`else
        compare("pass negative lane", sData[0], 32'hFFFF_FFF6);
`endif
        compare("relu positive lane", sData[1], 32'd7);
        repeat (2) applyStimulus(1'b0, 8'd1, 1'b1);

        // Random traffic against the model
        $display("[TB] random traffic");
        clearLog();
        for (int c = 0; c < 600; c++) begin
            bit st;
            st = (c == 0) || ($urandom_range(0, 39) == 0);
            enDrv = COLS'($urandom_range(0, (1 << COLS) - 1));
            for (int j = 0; j < COLS; j++) begin
                dataDrv[j] = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom);
            end
            applyStimulus(st, CNT_W'($urandom_range(0, 6)), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
